// File: rtl/store_buffer.sv
// ============================================================================
//  Module      : store_buffer
//  Description : DEPTH-entry circular store buffer between ROB commit and MEM.
//                Drains stores in program order with one outstanding write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer #(
   parameter int DEPTH   = 4,
   parameter int XLEN    = 32,
   parameter int TAG_LEN = 5
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     st_valid,
   input  logic [XLEN-1:0]          st_address,
   input  logic [XLEN-1:0]          st_data,
   input  logic [1:0]               st_size,
   input  logic [TAG_LEN-1:0]       st_rob_tag,
   input  logic                     mem_busy,
   input  logic                     mem_wr_ack,
   input  logic [XLEN-1:0]          load_address,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     pending_stores,
   output logic                     write_mem,
   output logic [XLEN-1:0]          mem_address,
   output logic [XLEN-1:0]          mem_data,
   output logic [1:0]               mem_size,
   output logic                     load_conflict
);

   localparam int c_PW = $clog2(DEPTH);
   localparam int c_CW = c_PW + 1;

   localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
   localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
   localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(DEPTH);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [c_PW-1:0]    head_q, head_d;
   logic [c_PW-1:0]    tail_q, tail_d;
   logic [c_CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic [XLEN-1:0]    addr_q [DEPTH];
   logic [XLEN-1:0]    addr_d [DEPTH];
   logic [XLEN-1:0]    data_q [DEPTH];
   logic [XLEN-1:0]    data_d [DEPTH];
   logic [1:0]         size_q [DEPTH];
   logic [1:0]         size_d [DEPTH];
   logic [TAG_LEN-1:0] tag_q  [DEPTH];
   logic [TAG_LEN-1:0] tag_d  [DEPTH];

   logic w_full;
   logic w_enq;
   logic w_pop;
   logic w_unused;

   // Full uses the registered count, so a same-cycle pop never frees a slot.
   assign w_full = (count_q == c_CNT_FULL);
   assign w_enq  = st_valid & ~w_full;
   assign w_pop  = (state_q == c_WAIT) & mem_wr_ack;

   // ROB tags are retained per entry but not consumed by this block.
   assign w_unused = ^{load_address[1:0], tag_q[head_q]};

   // ---------------- state register ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= c_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:  if ((count_q != '0) && !mem_busy) state_d = c_ISSUE;
         c_ISSUE: state_d = c_WAIT;
         c_WAIT:  if (mem_wr_ack) state_d = c_IDLE;
         default: state_d = c_IDLE;
      endcase
   end

   // ---------------- FSM outputs ----------------
   always_comb begin
      write_mem   = 1'b0;
      mem_address = '0;
      mem_data    = '0;
      mem_size    = 2'd0;
      if (state_q == c_ISSUE) write_mem = 1'b1;
      if (state_q != c_IDLE) begin
         mem_address = addr_q[head_q];
         mem_data    = data_q[head_q];
         mem_size    = size_q[head_q];
      end
   end

   // ---------------- FIFO datapath ----------------
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      size_d  = size_q;
      tag_d   = tag_q;
      if (w_pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + c_PTR_ONE;
      end
      if (w_enq) begin
         valid_d[tail_q] = 1'b1;
         addr_d[tail_q]  = st_address;
         data_d[tail_q]  = st_data;
         size_d[tail_q]  = st_size;
         tag_d[tail_q]   = st_rob_tag;
         tail_d          = tail_q + c_PTR_ONE;
      end
      case ({w_enq, w_pop})
         2'b10:   count_d = count_q + c_CNT_ONE;
         2'b01:   count_d = count_q - c_CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            size_q[i] <= 2'd0;
            tag_q[i]  <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         size_q  <= size_d;
         tag_q   <= tag_d;
      end
   end

   // Word-granular, conservative match against every valid entry.
   always_comb begin
      load_conflict = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i][XLEN-1:2] == load_address[XLEN-1:2])) begin
            load_conflict = 1'b1;
         end
      end
   end

   assign full           = w_full;
   assign count          = count_q;
   assign pending_stores = (count_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Self-checking bench for store_buffer against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  s;
   } ent_t;

   logic        clock;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_address;
   logic [31:0] st_data;
   logic [1:0]  st_size;
   logic [4:0]  st_rob_tag;
   logic        mem_busy;
   logic        mem_wr_ack;
   logic [31:0] load_address;
   logic        full;
   logic [2:0]  count;
   logic        pending_stores;
   logic        write_mem;
   logic [31:0] mem_address;
   logic [31:0] mem_data;
   logic [1:0]  mem_size;
   logic        load_conflict;

   store_buffer #(.DEPTH(4), .XLEN(32), .TAG_LEN(5)) dut (
      .clock          (clock),
      .reset          (reset),
      .st_valid       (st_valid),
      .st_address     (st_address),
      .st_data        (st_data),
      .st_size        (st_size),
      .st_rob_tag     (st_rob_tag),
      .mem_busy       (mem_busy),
      .mem_wr_ack     (mem_wr_ack),
      .load_address   (load_address),
      .full           (full),
      .count          (count),
      .pending_stores (pending_stores),
      .write_mem      (write_mem),
      .mem_address    (mem_address),
      .mem_data       (mem_data),
      .mem_size       (mem_size),
      .load_conflict  (load_conflict)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model: stores waiting in program order, plus the drain phase
   // (0 = nothing outstanding, 1 = request cycle, 2 = awaiting the ack).
   ent_t q[$];
   int   phase;
   int   wait_cycles;
   ent_t wlog[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      logic exp_lc;
      ent_t head;
      exp_lc = 1'b0;
      foreach (q[i]) if (q[i].a[31:2] == load_address[31:2]) exp_lc = 1'b1;
      head = (phase != 0 && q.size() != 0) ? q[0] : '0;
      chk("count",          32'(count),          32'(q.size()));
      chk("full",           32'(full),           32'(q.size() == 4));
      chk("pending_stores", 32'(pending_stores), 32'(q.size() != 0));
      chk("write_mem",      32'(write_mem),      32'(phase == 1));
      chk("mem_address",    mem_address,         head.a);
      chk("mem_data",       mem_data,            head.d);
      chk("mem_size",       32'(mem_size),       32'(head.s));
      chk("load_conflict",  32'(load_conflict),  32'(exp_lc));
      if (write_mem === 1'b1) wlog.push_back('{a: mem_address, d: mem_data, s: mem_size});
   endtask

   task automatic model_update();
      bit is_full, pop, enq;
      int nphase;
      is_full = (q.size() == 4);
      pop     = (phase == 2) && mem_wr_ack;
      enq     = st_valid && !is_full;
      case (phase)
         0:       nphase = (q.size() != 0 && !mem_busy) ? 1 : 0;
         1:       nphase = 2;
         default: nphase = mem_wr_ack ? 0 : 2;
      endcase
      if (pop) void'(q.pop_front());
      if (enq) q.push_back('{a: st_address, d: st_data, s: st_size});
      wait_cycles = (nphase == 2) ? ((phase == 2) ? wait_cycles + 1 : 0) : 0;
      phase = nphase;
   endtask

   // Called shortly after a rising edge with inputs already applied.
   task automatic step();
      #1;
      check_all();
      model_update();
      @(posedge clock);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      st_valid   = 1'b1;
      st_address = a;
      st_data    = d;
      st_size    = s;
      st_rob_tag = 5'($urandom);
      step();
      st_valid   = 1'b0;
   endtask

   // Acks on the second WAIT cycle; bounded so a stuck DUT still terminates.
   task automatic drain(input int max_cycles);
      int cyc;
      cyc = 0;
      mem_busy = 1'b0;
      while ((q.size() != 0 || phase != 0) && cyc < max_cycles) begin
         mem_wr_ack = (phase == 2) && (wait_cycles >= 1);
         step();
         cyc++;
      end
      mem_wr_ack = 1'b0;
      if (cyc >= max_cycles) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d cycles required below %0d", cyc, max_cycles);
      end
   endtask

   task automatic mid_cycle_reset();
      #2 reset = 1'b1;
      #1;
      chk("rst_write_mem",   32'(write_mem),      32'h0);
      chk("rst_mem_address", mem_address,         32'h0);
      chk("rst_mem_data",    mem_data,            32'h0);
      chk("rst_count",       32'(count),          32'h0);
      chk("rst_pending",     32'(pending_stores), 32'h0);
      q.delete();
      phase       = 0;
      wait_cycles = 0;
      #1 reset = 1'b0;
   endtask

   initial begin
      st_valid     = 1'b0;
      st_address   = '0;
      st_data      = '0;
      st_size      = 2'd0;
      st_rob_tag   = '0;
      mem_busy     = 1'b0;
      mem_wr_ack   = 1'b0;
      load_address = '0;
      phase        = 0;
      wait_cycles  = 0;
      reset        = 1'b1;

      // Reset before any clock edge.
      #2;
      chk("reset_count",     32'(count),          32'h0);
      chk("reset_full",      32'(full),           32'h0);
      chk("reset_pending",   32'(pending_stores), 32'h0);
      chk("reset_write_mem", 32'(write_mem),      32'h0);
      chk("reset_mem_addr",  mem_address,         32'h0);
      chk("reset_mem_data",  mem_data,            32'h0);
      chk("reset_mem_size",  32'(mem_size),       32'h0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Single store drains as one write carrying its values.
      wlog.delete();
      store(32'h100, 32'hDEADBEEF, 2'd2);
      drain(20);
      chk("t2_write_count", 32'(wlog.size()), 32'd1);
      if (wlog.size() >= 1) begin
         chk("t2_addr", wlog[0].a, 32'h100);
         chk("t2_data", wlog[0].d, 32'hDEADBEEF);
         chk("t2_size", 32'(wlog[0].s), 32'd2);
      end

      // Fill while MEM is busy; fifth store is dropped.
      wlog.delete();
      mem_busy = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         store(32'(i * 16), 32'(32'hA0 + i), 2'd2);
         if (i == 4) chk("t3_full_after_4", 32'(full), 32'h1);
      end
      chk("t3_count_after_5", 32'(count), 32'd4);
      drain(60);
      chk("t3_write_count", 32'(wlog.size()), 32'd4);
      for (int i = 0; i < 4 && i < wlog.size(); i++)
         chk("t3_order", wlog[i].a, 32'((i + 1) * 16));

      // Stream with enqueues landing on pop cycles, across pointer wrap.
      wlog.delete();
      mem_busy = 1'b0;
      for (int i = 0; i < 7; i++) begin
         mem_wr_ack = (phase == 2);
         store(32'h200 + 32'(i * 4), 32'(i), 2'(i % 3));
         mem_wr_ack = (phase == 2);
         step();
      end
      mem_wr_ack = 1'b0;
      drain(80);
      chk("t4_write_count", 32'(wlog.size()), 32'd7);
      for (int i = 0; i < 7 && i < wlog.size(); i++)
         chk("t4_order", wlog[i].a, 32'h200 + 32'(i * 4));

      // Word-granular load conflict.
      mem_busy = 1'b1;
      store(32'h104, 32'h5, 2'd0);
      load_address = 32'h106;
      #1 chk("t5_conflict_106", 32'(load_conflict), 32'h1);
      load_address = 32'h108;
      #1 chk("t5_conflict_108", 32'(load_conflict), 32'h0);
      load_address = 32'h106;
      drain(20);
      #1 chk("t5_conflict_after", 32'(load_conflict), 32'h0);

      // Reset while waiting for an ack, then resume normally.
      store(32'h300, 32'h33, 2'd2);
      for (int i = 0; i < 10 && phase != 2; i++) step();
      chk("t6_reached_wait", 32'(phase), 32'd2);
      mid_cycle_reset();
      wlog.delete();
      store(32'h400, 32'h44, 2'd1);
      drain(20);
      chk("t6_write_count", 32'(wlog.size()), 32'd1);
      if (wlog.size() >= 1) chk("t6_addr", wlog[0].a, 32'h400);

      // Randomized traffic with overlapping addresses.
      for (int i = 0; i < 400; i++) begin
         st_valid     = ($urandom_range(0, 2) != 0);
         st_address   = 32'h1000 + 32'($urandom_range(0, 31));
         st_data      = $urandom;
         st_size      = 2'($urandom_range(0, 2));
         st_rob_tag   = 5'($urandom);
         mem_busy     = ($urandom_range(0, 3) == 0);
         mem_wr_ack   = ($urandom_range(0, 1) == 1);
         load_address = 32'h1000 + 32'($urandom_range(0, 35));
         step();
      end
      st_valid = 1'b0;
      drain(40);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
